// File: rtl/pipe_pkg.sv
// Shared control-bundle layout for the pipeline stage registers.
// Stages slice WB/MEM/EX fields by name through ctrl_t.
package pipe_pkg;

  localparam int WB_W   = 2;
  localparam int MEM_W  = 2;
  localparam int EX_W   = 4;
  localparam int CTRL_W = WB_W + MEM_W + EX_W;

  localparam int EX_LSB  = 0;
  localparam int MEM_LSB = EX_LSB + EX_W;
  localparam int WB_LSB  = MEM_LSB + MEM_W;

  typedef struct packed {
    logic [WB_W-1:0]  wb;
    logic [MEM_W-1:0] mem;
    logic [EX_W-1:0]  ex;
  } ctrl_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake, flush and profiling signals of one pipeline stage register.
interface pipe_stage_reg_if #(
  parameter int CTRL_W    = pipe_pkg::CTRL_W,
  parameter int DATA_W    = 148,
  parameter int BUB_CNT_W = 16
);
  import pipe_pkg::*;

  logic                 valid_i;
  logic                 ready_o;
  logic [CTRL_W-1:0]    ctrl_i;
  logic [DATA_W-1:0]    data_i;
  logic                 flush_i;
  logic                 valid_o;
  logic                 ready_i;
  logic [CTRL_W-1:0]    ctrl_o;
  logic [DATA_W-1:0]    data_o;
  logic [BUB_CNT_W-1:0] bub_cnt_o;

  modport slave (
    input  valid_i, ctrl_i, data_i, flush_i, ready_i,
    output ready_o, valid_o, ctrl_o, data_o, bub_cnt_o
  );

  modport master (
    output valid_i, ctrl_i, data_i, flush_i, ready_i,
    input  ready_o, valid_o, ctrl_o, data_o, bub_cnt_o
  );

endinterface

// File: rtl/pipe_skid_buf.sv
// One-entry skid holding a beat that arrived while the output register was stalled.
module pipe_skid_buf #(
  parameter int CTRL_W = pipe_pkg::CTRL_W,
  parameter int DATA_W = 148
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load,
  input  logic              drain,
  input  logic [CTRL_W-1:0] ld_ctrl,
  input  logic [DATA_W-1:0] ld_data,
  output logic              full,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);
  import pipe_pkg::*;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full <= 1'b0;
      ctrl <= '0;
      data <= '0;
    end else if (drain) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      ctrl <= ld_ctrl;
      data <= ld_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register with valid/ready, flush-to-bubble and bubble counter.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid that registers ready_o.
module pipe_stage_reg #(
  parameter int CTRL_W    = pipe_pkg::CTRL_W,
  parameter int DATA_W    = 148,
  parameter int BUB_CNT_W = 16
) (
  input logic             clk_i,
  input logic             rst_i,
  pipe_stage_reg_if.slave bus
);
  import pipe_pkg::*;

  logic                 valid_q;
  logic [CTRL_W-1:0]    ctrl_q;
  logic [DATA_W-1:0]    data_q;
  logic [BUB_CNT_W-1:0] bub_q;
  logic                 in_xfer;
  logic                 out_xfer;

  assign in_xfer       = bus.valid_i & bus.ready_o;
  assign out_xfer      = valid_q & bus.ready_i;
  assign bus.valid_o   = valid_q;
  assign bus.ctrl_o    = ctrl_q;
  assign bus.data_o    = data_q;
  assign bus.bub_cnt_o = bub_q;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_full;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              skid_load;
  logic              skid_drain;

  // A new beat goes to the skid only when the output register is occupied and stalled.
  assign bus.ready_o = ~skid_full;
  assign skid_load   = ~bus.flush_i & in_xfer & valid_q & ~bus.ready_i;
  assign skid_drain  = bus.flush_i | (skid_full & out_xfer);

  pipe_skid_buf #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load    (skid_load),
    .drain   (skid_drain),
    .ld_ctrl (bus.ctrl_i),
    .ld_data (bus.data_i),
    .full    (skid_full),
    .ctrl    (skid_ctrl),
    .data    (skid_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (bus.flush_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (skid_full) begin
      if (out_xfer) begin
        ctrl_q <= skid_ctrl;
        data_q <= skid_data;
      end
    end else if (in_xfer && !skid_load) begin
      valid_q <= 1'b1;
      ctrl_q  <= bus.ctrl_i;
      data_q  <= bus.data_i;
    end else if (out_xfer) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end
  end
`else
  assign bus.ready_o = bus.ready_i | ~valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (bus.flush_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (in_xfer) begin
      valid_q <= 1'b1;
      ctrl_q  <= bus.ctrl_i;
      data_q  <= bus.data_i;
    end else if (out_xfer) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end
  end
`endif

  // Counts downstream-ready cycles with nothing to offer; sticks at all-ones.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bub_q <= '0;
    end else if (bus.ready_i && !valid_q && (bub_q != {BUB_CNT_W{1'b1}})) begin
      bub_q <= bub_q + 1'b1;
    end
  end

endmodule
